// File: rtl/tdc_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tdc_ctrl_pkg                                                 |
// | Description : Shared types and constants for the TDC measurement           |
// |               sequencer: FSM state encoding, mux select values and         |
// |               elaboration-time parameter range checks.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package tdc_ctrl_pkg;

    // Sequencer states, explicitly 3 bits wide
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MEAS      = 3'd1,
        ST_CAL_SETUP = 3'd2,
        ST_CAL_FIRE  = 3'd3,
        ST_CAL_MEAS  = 3'd4,
        ST_RESULT    = 3'd5
    } tdc_state_t;

    // Sampling-stage mux select values
    localparam logic SEL_HIT = 1'b0;  // physical hit path
    localparam logic SEL_CAL = 1'b1;  // calibration loopback path

    // Largest value representable in a cnt_w-bit counter
    function automatic longint max_count(input int cnt_w);
        return (longint'(1) << cnt_w) - longint'(1);
    endfunction

    // TIMEOUT must be reachable by the coarse counter without wrapping
    function automatic bit timeout_ok(input int cnt_w, input int timeout);
        return (timeout >= 1) && (longint'(timeout) <= max_count(cnt_w));
    endfunction

    // A calibration run needs at least one loopback measurement
    function automatic bit cal_cycles_ok(input int cal_cycles);
        return cal_cycles >= 1;
    endfunction

    // The settle wait reuses the coarse counter, so it must fit in it
    function automatic bit settle_ok(input int cnt_w, input int settle);
        return (settle >= 0) && (longint'(settle) <= max_count(cnt_w));
    endfunction

endpackage : tdc_ctrl_pkg
`default_nettype wire

// File: rtl/tdc_coarse_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tdc_coarse_cnt                                               |
// | Description : Coarse measurement counter with synchronous clear, count     |
// |               enable and a terminal flag raised at TIMEOUT-1.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tdc_coarse_cnt #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_sclr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_term
);

    localparam logic [CNT_W-1:0] c_term_val = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // Count up while enabled; the sync clear wins so a new measurement always starts at zero
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cnt <= '0;
        end else if (i_sclr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + c_one;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_term = (r_cnt == c_term_val);

endmodule : tdc_coarse_cnt
`default_nettype wire

// File: rtl/tdc_meas_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tdc_meas_ctrl                                                |
// | Description : Measurement sequencer for the TDC select-mux-plus-flop       |
// |               stage. Steers the mux, fires calibration pulses, times the   |
// |               first rising edge of hit_s with a coarse counter and hands   |
// |               the count to readout over a valid/ready port.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tdc_meas_ctrl
    import tdc_ctrl_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 1000,
    parameter int CAL_CYCLES = 8,
    parameter int SETTLE     = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start_i,
    input  logic             cal_req,
    input  logic             hit_s,
    output logic             sel,
    output logic             cal_pulse,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_cal,
    output logic             result_to,
    output logic             result_valid,
    input  logic             result_ready
);

    localparam int                c_idx_w       = $clog2(CAL_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  c_timeout_val = CNT_W'(TIMEOUT);
    // A zero settle time still spends one cycle in CAL_SETUP
    localparam logic [CNT_W-1:0]  c_settle_last = CNT_W'((SETTLE > 0) ? (SETTLE - 1) : 0);
    localparam logic [c_idx_w-1:0] c_cal_last   = c_idx_w'(CAL_CYCLES - 1);
    localparam logic [c_idx_w-1:0] c_idx_one    = c_idx_w'(1);

    // Reject parameter sets the counter or calibration loop cannot honour
    if (!timeout_ok(CNT_W, TIMEOUT)) begin : g_chk_timeout
        $error("tdc_meas_ctrl: TIMEOUT must be in 1..2**CNT_W-1");
    end
    if (!cal_cycles_ok(CAL_CYCLES)) begin : g_chk_cal_cycles
        $error("tdc_meas_ctrl: CAL_CYCLES must be at least 1");
    end
    if (!settle_ok(CNT_W, SETTLE)) begin : g_chk_settle
        $error("tdc_meas_ctrl: SETTLE must fit in the coarse counter");
    end

    tdc_state_t         r_state;
    tdc_state_t         w_state_nxt;

    logic               r_sel;
    logic               r_cal_pulse;
    logic [CNT_W-1:0]   r_result;
    logic               r_result_cal;
    logic               r_result_to;
    logic               r_result_valid;
    logic               r_cal_pending;
    logic [c_idx_w-1:0] r_cal_idx;
    logic               r_hit_d;

    logic               w_sel_nxt;
    logic               w_cal_pulse_nxt;
    logic [CNT_W-1:0]   w_result_nxt;
    logic               w_result_cal_nxt;
    logic               w_result_to_nxt;
    logic               w_result_valid_nxt;
    logic               w_cal_pending_nxt;
    logic [c_idx_w-1:0] w_cal_idx_nxt;

    logic               w_cnt_sclr;
    logic               w_cnt_en;
    logic [CNT_W-1:0]   w_cnt;
    logic               w_cnt_term;
    logic               w_edge;
    logic               w_busy;

    tdc_coarse_cnt #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_coarse_cnt (
        .clk    (clk),
        .clr    (clr),
        .i_sclr (w_cnt_sclr),
        .i_en   (w_cnt_en),
        .o_cnt  (w_cnt),
        .o_term (w_cnt_term)
    );

    // A stop is a fresh rising edge; a level already high on entry is not one
    assign w_edge = hit_s & ~r_hit_d;
    assign w_busy = (r_state != ST_IDLE);

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus next values of every registered output
    always_comb begin
        w_state_nxt        = r_state;
        w_sel_nxt          = r_sel;
        w_cal_pulse_nxt    = 1'b0;
        w_result_nxt       = r_result;
        w_result_cal_nxt   = r_result_cal;
        w_result_to_nxt    = r_result_to;
        w_result_valid_nxt = r_result_valid;
        w_cal_pending_nxt  = r_cal_pending;
        w_cal_idx_nxt      = r_cal_idx;
        w_cnt_sclr         = 1'b0;
        w_cnt_en           = 1'b0;

        // Calibration requests arriving mid-operation are remembered, starts are not
        if (w_busy && cal_req) begin
            w_cal_pending_nxt = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (cal_req || r_cal_pending) begin
                    w_state_nxt       = ST_CAL_SETUP;
                    w_cal_pending_nxt = 1'b0;
                    w_cal_idx_nxt     = '0;
                    w_sel_nxt         = SEL_CAL;
                    w_cnt_sclr        = 1'b1;
                end else if (start_i) begin
                    w_state_nxt = ST_MEAS;
                    w_cnt_sclr  = 1'b1;
                end
            end

            ST_MEAS, ST_CAL_MEAS: begin
                if (w_edge) begin
                    w_state_nxt        = ST_RESULT;
                    w_result_nxt       = w_cnt;
                    w_result_to_nxt    = 1'b0;
                    w_result_cal_nxt   = (r_state == ST_CAL_MEAS);
                    w_result_valid_nxt = 1'b1;
                end else if (w_cnt_term) begin
                    w_state_nxt        = ST_RESULT;
                    w_result_nxt       = c_timeout_val;
                    w_result_to_nxt    = 1'b1;
                    w_result_cal_nxt   = (r_state == ST_CAL_MEAS);
                    w_result_valid_nxt = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end

            ST_CAL_SETUP: begin
                // Counter doubles as the settle timer while the mux path settles
                if (w_cnt == c_settle_last) begin
                    w_state_nxt     = ST_CAL_FIRE;
                    w_cal_pulse_nxt = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end

            ST_CAL_FIRE: begin
                w_state_nxt = ST_CAL_MEAS;
                w_cnt_sclr  = 1'b1;
            end

            ST_RESULT: begin
                if (result_ready) begin
                    w_result_valid_nxt = 1'b0;
                    if (r_result_cal && (r_cal_idx < c_cal_last)) begin
                        w_state_nxt   = ST_CAL_SETUP;
                        w_cal_idx_nxt = r_cal_idx + c_idx_one;
                        w_cnt_sclr    = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_sel_nxt   = SEL_HIT;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered outputs and bookkeeping; the edge-detect delay runs in every state
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_sel          <= SEL_HIT;
            r_cal_pulse    <= 1'b0;
            r_result       <= '0;
            r_result_cal   <= 1'b0;
            r_result_to    <= 1'b0;
            r_result_valid <= 1'b0;
            r_cal_pending  <= 1'b0;
            r_cal_idx      <= '0;
            r_hit_d        <= 1'b0;
        end else begin
            r_sel          <= w_sel_nxt;
            r_cal_pulse    <= w_cal_pulse_nxt;
            r_result       <= w_result_nxt;
            r_result_cal   <= w_result_cal_nxt;
            r_result_to    <= w_result_to_nxt;
            r_result_valid <= w_result_valid_nxt;
            r_cal_pending  <= w_cal_pending_nxt;
            r_cal_idx      <= w_cal_idx_nxt;
            r_hit_d        <= hit_s;
        end
    end

    assign sel          = r_sel;
    assign cal_pulse    = r_cal_pulse;
    assign busy         = w_busy;
    assign result       = r_result;
    assign result_cal   = r_result_cal;
    assign result_to    = r_result_to;
    assign result_valid = r_result_valid;

endmodule : tdc_meas_ctrl
`default_nettype wire

// File: tb/tb_tdc_meas_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tdc_meas_ctrl                                             |
// | Description : Directed self-checking bench for tdc_meas_ctrl, with a       |
// |               behavioural select-mux-plus-flop closing the hit_s loop.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tdc_meas_ctrl;

    localparam int CNT_W      = 16;
    localparam int TIMEOUT    = 1000;
    localparam int CAL_CYCLES = 8;
    localparam int SETTLE     = 2;

    logic             clk          = 1'b0;
    logic             clr          = 1'b1;
    logic             start_i      = 1'b0;
    logic             cal_req      = 1'b0;
    logic             hit_s        = 1'b0;
    logic             result_ready = 1'b0;
    logic             sel;
    logic             cal_pulse;
    logic             busy;
    logic [CNT_W-1:0] result;
    logic             result_cal;
    logic             result_to;
    logic             result_valid;

    logic hit_phys = 1'b0;  // physical hit input to mux port A
    logic loop_en  = 1'b1;  // breaks the calibration loopback when low

    int checks = 0;
    int errors = 0;

    tdc_meas_ctrl #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .CAL_CYCLES (CAL_CYCLES),
        .SETTLE     (SETTLE)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .start_i      (start_i),
        .cal_req      (cal_req),
        .hit_s        (hit_s),
        .sel          (sel),
        .cal_pulse    (cal_pulse),
        .busy         (busy),
        .result       (result),
        .result_cal   (result_cal),
        .result_to    (result_to),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    // Sampling stage: select mux followed by one flop
    always @(posedge clk) hit_s <= sel ? (cal_pulse & loop_en) : hit_phys;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2 clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hit_phys = ~hit_phys;
            tick();
            checks++;
            if ({busy, sel, cal_pulse, result_valid, result_to, result_cal, result} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got busy=%b sel=%b pulse=%b valid=%b to=%b cal=%b result=%0d expected all 0",
                         busy, sel, cal_pulse, result_valid, result_to, result_cal, result);
            end
        end
        hit_phys = 1'b0;
        clr = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, sel, result_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b sel=%b valid=%b expected 000", busy, sel, result_valid);
        end
    endtask

    task automatic test_normal;
        start_i = 1'b1;
        tick();                       // t+1, MEAS
        start_i = 1'b0;
        checks++;
        if ({busy, sel} !== 2'b10) begin
            errors++;
            $display("FAIL normal_busy: got busy=%b sel=%b expected busy=1 sel=0", busy, sel);
        end
        repeat (4) tick();            // t+5
        hit_phys = 1'b1;
        tick();                       // t+6, hit_s rises
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL normal_early_valid: got %b expected 0", result_valid);
        end
        tick();                       // t+7
        checks++;
        if ({result_valid, result_cal, result_to} !== 3'b100 || result !== 16'd5) begin
            errors++;
            $display("FAIL normal_result: got valid=%b cal=%b to=%b result=%0d expected valid=1 cal=0 to=0 result=5",
                     result_valid, result_cal, result_to, result);
        end
        hit_phys = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({result_valid, result_cal, result_to} !== 3'b100 || result !== 16'd5) begin
                errors++;
                $display("FAIL normal_hold: got valid=%b cal=%b to=%b result=%0d expected held 1/0/0/5",
                         result_valid, result_cal, result_to, result);
            end
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        checks++;
        if ({busy, result_valid} !== 2'b00) begin
            errors++;
            $display("FAIL normal_handshake: got busy=%b valid=%b expected 00", busy, result_valid);
        end
    endtask

    task automatic test_timeout;
        int n;
        hit_phys = 1'b0;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        n = 1;
        while (result_valid !== 1'b1 && n < 1100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 1001) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles expected 1001", n);
        end
        checks++;
        if (result !== 16'd1000 || result_to !== 1'b1 || result_cal !== 1'b0) begin
            errors++;
            $display("FAIL timeout_result: got result=%0d to=%b cal=%b expected 1000/1/0", result, result_to, result_cal);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_cal;
        int n_busy, n_pulse, n_res, n_double, bad_sel, bad_res;
        logic prev_pulse;
        n_busy = 0; n_pulse = 0; n_res = 0; n_double = 0; bad_sel = 0; bad_res = 0;
        prev_pulse = 1'b0;
        cal_req = 1'b1;
        tick();
        cal_req = 1'b0;
        result_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (busy !== 1'b1) break;
            n_busy++;
            if (cal_pulse === 1'b1) begin
                n_pulse++;
                if (prev_pulse === 1'b1) n_double++;
            end
            prev_pulse = cal_pulse;
            if (sel !== 1'b1) bad_sel++;
            if (result_valid === 1'b1) begin
                n_res++;
                if (result !== 16'd0 || result_cal !== 1'b1 || result_to !== 1'b0) bad_res++;
            end
            tick();
        end
        result_ready = 1'b0;
        checks++;
        if (n_busy != 40) begin
            errors++;
            $display("FAIL cal_run_length: got %0d busy cycles expected 40", n_busy);
        end
        checks++;
        if (n_pulse != 8 || n_double != 0) begin
            errors++;
            $display("FAIL cal_pulses: got %0d pulses (%0d wide) expected 8 single-cycle", n_pulse, n_double);
        end
        checks++;
        if (n_res != 8 || bad_res != 0) begin
            errors++;
            $display("FAIL cal_results: got %0d results (%0d wrong) expected 8 with result=0 cal=1", n_res, bad_res);
        end
        checks++;
        if (bad_sel != 0) begin
            errors++;
            $display("FAIL cal_sel_during_run: got %0d cycles with sel=0 expected 0", bad_sel);
        end
        checks++;
        if ({sel, busy} !== 2'b00) begin
            errors++;
            $display("FAIL cal_end: got sel=%b busy=%b expected 00", sel, busy);
        end
    endtask

    task automatic test_arbitration;
        int n;
        // Simultaneous start and calibration request
        start_i = 1'b1;
        cal_req = 1'b1;
        tick();
        start_i = 1'b0;
        cal_req = 1'b0;
        checks++;
        if ({sel, busy} !== 2'b11) begin
            errors++;
            $display("FAIL arb_cal_wins: got sel=%b busy=%b expected 11", sel, busy);
        end
        result_ready = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            tick();
            n++;
        end
        result_ready = 1'b0;
        checks++;
        if (n != 40 || result_cal !== 1'b1) begin
            errors++;
            $display("FAIL arb_cal_only: got %0d cycles cal=%b expected 40 cycles cal=1", n, result_cal);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL arb_start_dropped: got busy=%b expected 0", busy);
        end

        // Second start while measuring must not restart the count
        start_i = 1'b1;
        tick();                       // t+1
        start_i = 1'b0;
        tick();                       // t+2
        start_i = 1'b1;
        tick();                       // t+3
        start_i = 1'b0;
        hit_phys = 1'b1;
        tick();                       // t+4, edge
        tick();                       // t+5
        checks++;
        if (result_valid !== 1'b1 || result !== 16'd3 || result_cal !== 1'b0) begin
            errors++;
            $display("FAIL arb_start_ignored: got valid=%b result=%0d cal=%b expected 1/3/0", result_valid, result, result_cal);
        end
        hit_phys = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL arb_no_requeue: got busy=%b expected 0", busy);
        end

        // Calibration request during a measurement is deferred until after its result
        start_i = 1'b1;
        tick();                       // t+1
        start_i = 1'b0;
        tick();                       // t+2
        cal_req = 1'b1;
        tick();                       // t+3
        cal_req = 1'b0;
        hit_phys = 1'b1;
        tick();                       // t+4
        tick();                       // t+5
        checks++;
        if (result_valid !== 1'b1 || result !== 16'd3 || result_cal !== 1'b0) begin
            errors++;
            $display("FAIL arb_meas_before_cal: got valid=%b result=%0d cal=%b expected 1/3/0", result_valid, result, result_cal);
        end
        hit_phys = 1'b0;
        result_ready = 1'b1;
        tick();                       // t+6, IDLE
        checks++;
        if ({busy, sel} !== 2'b00) begin
            errors++;
            $display("FAIL arb_pending_idle: got busy=%b sel=%b expected 00", busy, sel);
        end
        tick();                       // t+7, CAL_SETUP
        checks++;
        if ({busy, sel} !== 2'b11) begin
            errors++;
            $display("FAIL arb_pending_served: got busy=%b sel=%b expected 11", busy, sel);
        end
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            tick();
            n++;
        end
        result_ready = 1'b0;
        checks++;
        if (n != 40) begin
            errors++;
            $display("FAIL arb_pending_run: got %0d busy cycles expected 40", n);
        end
    endtask

    task automatic test_edge_cases;
        // Stop level already high when the measurement begins
        hit_phys = 1'b1;
        tick();
        tick();
        start_i = 1'b1;
        tick();                       // t+1
        start_i = 1'b0;
        repeat (4) tick();            // t+5
        checks++;
        if ({busy, result_valid} !== 2'b10) begin
            errors++;
            $display("FAIL edge_high_ignored: got busy=%b valid=%b expected 10", busy, result_valid);
        end
        hit_phys = 1'b0;
        tick();                       // t+6, hit_s low
        hit_phys = 1'b1;
        tick();                       // t+7, hit_s rises
        tick();                       // t+8
        checks++;
        if (result_valid !== 1'b1 || result !== 16'd6) begin
            errors++;
            $display("FAIL edge_refire: got valid=%b result=%0d expected 1/6", result_valid, result);
        end
        hit_phys = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;

        // Reset in the middle of a calibration measurement
        loop_en = 1'b0;
        cal_req = 1'b1;
        tick();                       // c+1 CAL_SETUP
        cal_req = 1'b0;
        tick();                       // c+2
        tick();                       // c+3 CAL_FIRE
        checks++;
        if (cal_pulse !== 1'b1) begin
            errors++;
            $display("FAIL edge_cal_fire: got cal_pulse=%b expected 1", cal_pulse);
        end
        tick();                       // c+4 CAL_MEAS
        tick();                       // c+5
        cal_req = 1'b1;
        tick();                       // c+6, pending set
        cal_req = 1'b0;
        checks++;
        if ({busy, result_valid, sel} !== 3'b101) begin
            errors++;
            $display("FAIL edge_in_cal_meas: got busy=%b valid=%b sel=%b expected 101", busy, result_valid, sel);
        end
        #2 clr = 1'b0;
        #1;
        checks++;
        if ({busy, sel, result_valid, cal_pulse} !== 4'b0000) begin
            errors++;
            $display("FAIL edge_async_clr: got busy=%b sel=%b valid=%b pulse=%b expected 0000", busy, sel, result_valid, cal_pulse);
        end
        #2 clr = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, sel} !== 2'b00) begin
            errors++;
            $display("FAIL edge_pending_cleared: got busy=%b sel=%b expected 00", busy, sel);
        end
        loop_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_timeout();
        test_cal();
        test_arbitration();
        test_edge_cases();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_tdc_meas_ctrl
`default_nettype wire

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
Measurement sequencer for the TDC front-end's select-mux-plus-flop stage.
- Drives the mux select (0 = physical hit path, 1 = calibration path) and generates calibration pulses.
- Runs a coarse counter from start until the registered mux output `hit_s` shows a rising edge, then presents the count on a valid/ready result port.
- Sits between the FFMUX-style sampling stage and the readout logic.

Parameters:
- CNT_W, 16, coarse counter and result width.
- TIMEOUT, 1000, max coarse cycles per measurement; must be ≤ 2^CNT_W-1.
- CAL_CYCLES, 8, loopback measurements per calibration run; must be ≥ 1.
- SETTLE, 2, cycles waited after a select change before a calibration pulse fires.

Ports:
- clk, in, 1, system clock; all state updates on posedge.
- clr, in, 1, asynchronous active-low reset.
- start_i, in, 1, single-cycle measurement request.
- cal_req, in, 1, single-cycle calibration-run request.
- hit_s, in, 1, registered mux output (stop/loopback signal).
- sel, out, 1, mux select to the sampling stage; registered.
- cal_pulse, out, 1, calibration pulse into mux input B; registered, 1 cycle wide.
- busy, out, 1, high when state != IDLE.
- result, out, CNT_W, coarse count.
- result_cal, out, 1, result came from a calibration measurement.
- result_to, out, 1, result is a timeout.
- result_valid, out, 1, result handshake valid.
- result_ready, in, 1, result handshake ready.

Behaviour:
- **Reset.** clr=0 forces, asynchronously, state=IDLE and sel, cal_pulse, result, result_cal, result_to, result_valid, cal_pending, cal_idx, cnt and hit_d all to 0. This holds mid-operation; any in-flight measurement is discarded.
- **Edge detect.** hit_d <= hit_s every cycle in every state. An edge is hit_s=1 && hit_d=0. A hit_s already high at MEAS entry does not count until it falls and rises again.
- **States:** IDLE, MEAS, CAL_SETUP, CAL_FIRE, CAL_MEAS, RESULT.
- **IDLE.**
  - sel=0.
  - If cal_req or cal_pending: go to CAL_SETUP, clear cal_pending, cal_idx=0.
  - Else if start_i: go to MEAS with cnt=0.
  - Simultaneous start_i and cal_req: calibration wins and start_i is dropped.
- **MEAS.** Per cycle, in priority order:
  - Edge: result<=cnt, result_to<=0, result_cal<=0, go to RESULT.
  - Else if cnt==TIMEOUT-1: result<=TIMEOUT, result_to<=1, go to RESULT.
  - Else: cnt++.
- **MEAS latency.** start_i high at cycle t → MEAS from t+1. An edge at cycle t+1+k gives result=k with result_valid high from t+2+k.
- **CAL_SETUP.** sel<=1; wait SETTLE cycles, then go to CAL_FIRE.
- **CAL_FIRE.** cal_pulse=1 for exactly this one cycle; next state CAL_MEAS with cnt=0.
- **CAL_MEAS.** Same as MEAS, except result_cal<=1. Direct loopback (hit_s = cal_pulse delayed by one flop) yields result=0.
- **RESULT.**
  - result_valid=1. result, result_cal and result_to are stable while result_valid && !result_ready.
  - On result_ready: result_valid<=0.
  - Next state after a calibration result: CAL_SETUP with cal_idx++ if cal_idx<CAL_CYCLES-1; otherwise IDLE with sel<=0.
  - Next state after a normal result: IDLE.
- **Requests while busy.**
  - start_i while busy is ignored (no queue).
  - cal_req while busy sets cal_pending, served on the next IDLE cycle.
- **Widths.** cnt is CNT_W bits and never wraps, because TIMEOUT bounds it. cal_idx is $clog2(CAL_CYCLES)+1 bits.
- **Observability.** sel changes only in IDLE→CAL_SETUP and RESULT→IDLE, so the datapath never sees a select glitch during a measurement.

Decomposition:
- Package tdc_ctrl_pkg: state encoding; SEL_HIT=1'b0; SEL_CAL=1'b1; shared parameter range checks.
- One natural sub-module, tdc_coarse_cnt: counter with sync clear, enable, terminal flag at TIMEOUT-1, and asynchronous active-low clr.

Test Plan:
1. **Reset.** Assert clr=0 for 3 cycles, with hit_s toggling → all outputs 0, busy=0. Release → still idle.
2. **Normal measurement.** start_i at t; hit_s rises at t+6 → result=5, result_cal=0, result_to=0, result_valid at t+7. Hold result_ready=0 for 4 cycles → outputs stable; handshake done → busy=0.
3. **Timeout.** start_i with hit_s=0 throughout, TIMEOUT=1000 → result=1000, result_to=1, valid 1001 cycles after start.
4. **Calibration run.** cal_req with hit_s looped back through the mux+flop, result_ready=1 → 8 results, each result=0 and result_cal=1; exactly 8 single-cycle cal_pulse; sel=1 for the whole run; sel=0 after the final handshake.
5. **Request arbitration.**
   - start_i and cal_req in the same IDLE cycle → calibration run only.
   - start_i during MEAS → ignored.
   - cal_req during MEAS → calibration starts right after that result.
6. **Edge cases.**
   - hit_s held high before start_i → no result until hit_s falls and rises.
   - clr pulsed mid-CAL_MEAS → immediate IDLE, sel=0, result_valid=0, cal_pending=0.
